// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: byte width, default
// operand width, the sequencer state encoding and a counter-width helper.
package alu_operand_sequencer_pkg;

    localparam int BYTE_W       = 8;
    localparam int DEFAULT_BITS = 16;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } seq_state_e;

    // Byte counters index NBYTES bytes but never shrink below one bit,
    // so an 8-bit build still has a legal (constant-zero) counter.
    function automatic int cnt_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_byte_deserializer.sv
// Little-endian byte-to-word assembler: each enabled byte lands in the slot
// selected by an internal counter; done pulses alongside the final byte.
module alu_operand_sequencer_byte_deserializer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [BITS-1:0]   value,
    output logic              done
);

    localparam int NBYTES = BITS / BYTE_W;
    localparam int CW     = cnt_width(NBYTES);

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(NBYTES - 1));
    // done is combinational so the FSM can change state on the same edge
    // that stores the final byte.
    assign done = en && last;

    // Insert the incoming byte at the counter position and advance/wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            value <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
            for (int i = 0; i < NBYTES; i++) begin
                if (cnt == CW'(i)) begin
                    value[i*BYTE_W +: BYTE_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and an opcode byte from the UART receive
// stream, presents them to a combinational Alu, captures its result one
// cycle later and streams the result back out LSB-first.
//
// tx handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both high; while tx_ready is low, tx_valid and tx_data are
// held unchanged. rx has no back-pressure: rx_valid is a one-cycle strobe,
// and bytes arriving while the block is not collecting input are dropped
// and flagged on the sticky overrun output.
//
// BITS must be a multiple of 8 and at least 8.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BITS-1:0]   alu_a,
    output logic [BITS-1:0]   alu_b,
    output logic [BITS-1:0]   alu_op,
    input  logic [BITS-1:0]   alu_r,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overrun,
    output seq_state_e        dbg_state
);

    localparam int NBYTES = BITS / BYTE_W;
    localparam int CW     = cnt_width(NBYTES);

    seq_state_e        state;
    seq_state_e        state_next;

    logic [CW-1:0]     tx_cnt;
    logic              tx_last;
    logic              tx_fire;
    logic [BITS-1:0]   result;
    logic [BITS-1:0]   op_q;
    logic              overrun_q;
    logic [BYTE_W-1:0] tx_byte;

    logic              a_en;
    logic              b_en;
    logic              a_done;
    logic              b_done;
    logic              busy;

    alu_operand_sequencer_byte_deserializer #(.BITS(BITS)) u_des_a (
        .clk   (clk),
        .rst   (rst),
        .en    (a_en),
        .data  (rx_data),
        .value (alu_a),
        .done  (a_done)
    );

    alu_operand_sequencer_byte_deserializer #(.BITS(BITS)) u_des_b (
        .clk   (clk),
        .rst   (rst),
        .en    (b_en),
        .data  (rx_data),
        .value (alu_b),
        .done  (b_done)
    );

    assign alu_op    = op_q;
    assign overrun   = overrun_q;
    assign dbg_state = state;
    assign tx_last   = (tx_cnt == CW'(NBYTES - 1));
    assign busy      = (state == EXEC) || (state == SEND);

    // Pick the result byte addressed by the transmit counter.
    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (tx_cnt == CW'(i)) begin
                tx_byte = result[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the per-state enables and transmit outputs.
    always_comb begin
        state_next = state;
        a_en       = 1'b0;
        b_en       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_fire    = 1'b0;
        case (state)
            GET_A: begin
                a_en = rx_valid;
                if (a_done) begin
                    state_next = GET_B;
                end
            end
            GET_B: begin
                b_en = rx_valid;
                if (b_done) begin
                    state_next = GET_OP;
                end
            end
            GET_OP: begin
                if (rx_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Single settle cycle: Alu inputs are already registered.
                state_next = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = tx_byte;
                tx_fire  = tx_ready;
                if (tx_ready && tx_last) begin
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    // Opcode register, result capture, transmit counter and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            result    <= '0;
            tx_cnt    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (state == GET_OP && rx_valid) begin
                op_q <= BITS'(rx_data);
            end
            if (state == EXEC) begin
                result <= alu_r;
                tx_cnt <= '0;
            end
            if (tx_fire) begin
                tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
            end
            // A byte that shows up while executing or sending is lost,
            // including one coinciding with the final tx handshake.
            if (rx_valid && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a 16-bit instance against a queue-based
// transaction model, and an 8-bit instance checked with literal values.
module tb_alu_operand_sequencer;
    import alu_operand_sequencer_pkg::*;

    localparam int BITS = 16;
    localparam int NB   = BITS / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- 16-bit instance ----------------
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [BITS-1:0] alu_a, alu_b, alu_op, alu_r;
    logic [7:0]      tx_data;
    logic            tx_valid, tx_ready, overrun;
    seq_state_e      dbg_state;

    // Alu stub: R = A + B, wrapping at the operand width.
    assign alu_r = alu_a + alu_b;

    alu_operand_sequencer #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- 8-bit instance ----------------
    logic [7:0] rx_data8;
    logic       rx_valid8;
    logic [7:0] alu_a8, alu_b8, alu_op8, alu_r8;
    logic [7:0] tx_data8;
    logic       tx_valid8, tx_ready8, overrun8;
    seq_state_e dbg_state8;

    assign alu_r8 = alu_a8 + alu_b8;

    alu_operand_sequencer #(.BITS(8)) dut8 (
        .clk(clk), .rst(rst), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .alu_a(alu_a8), .alu_b(alu_b8), .alu_op(alu_op8), .alu_r(alu_r8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .overrun(overrun8), .dbg_state(dbg_state8)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model (16-bit) ----------------
    // A transaction is 2*NB+1 accepted bytes; the opcode byte pushes the
    // result bytes to exp_q. One cycle later they start going out, and the
    // block accepts input again once exp_q has drained.
    logic [7:0]      exp_q[$];
    int              m_rx_cnt = 0;
    bit              m_exec   = 0;
    bit              m_ovr    = 0;
    logic [BITS-1:0] m_a = '0, m_b = '0, m_op = '0;
    logic [7:0]      tx_log[$];
    int              tx_cyc[$];

    always @(negedge clk) begin
        bit              sending;
        int              idx;
        logic [BITS-1:0] res;
        if (rst) begin
            exp_q.delete();
            m_rx_cnt = 0;
            m_exec   = 0;
            m_ovr    = 0;
            m_a      = '0;
            m_b      = '0;
            m_op     = '0;
        end else begin
            sending = (exp_q.size() > 0) && !m_exec;
            check("overrun", overrun, m_ovr);
            check("tx_valid", tx_valid, sending);
            if (sending) begin
                check("tx_data", tx_data, exp_q[0]);
                check("alu_a_hold", alu_a, m_a);
                check("alu_b_hold", alu_b, m_b);
                check("alu_op_hold", alu_op, m_op);
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            m_exec = 0;
            if (rx_valid) begin
                if (m_rx_cnt < 2 * NB + 1) begin
                    idx = m_rx_cnt;
                    if (idx < NB) begin
                        m_a[idx*8 +: 8] = rx_data;
                    end else if (idx < 2 * NB) begin
                        m_b[(idx-NB)*8 +: 8] = rx_data;
                    end else begin
                        m_op = BITS'(rx_data);
                        res  = m_a + m_b;
                        for (int i = 0; i < NB; i++) exp_q.push_back(res[i*8 +: 8]);
                        m_exec = 1;
                    end
                    m_rx_cnt++;
                end else begin
                    m_ovr = 1;
                end
            end
            if (sending && tx_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_rx_cnt = 0;
            end
        end
    end

    // 8-bit instance handshake log.
    logic [7:0] log8[$];
    int         cyc8[$];
    always @(negedge clk) begin
        if (!rst && tx_valid8 && tx_ready8) begin
            log8.push_back(tx_data8);
            cyc8.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    bit rdy_rand = 0;
    bit stray_en = 0;
    int op_cyc   = 0;

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        op_cyc   = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_txn(input logic [7:0] a0, a1, b0, b1, op, input int max_gap);
        send_byte(a0, max_gap);
        send_byte(a1, max_gap);
        send_byte(b0, max_gap);
        send_byte(b1, max_gap);
        send_byte(op, max_gap);
    endtask

    // Wait for the model to report the transaction fully sent.
    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (m_rx_cnt == 0 && exp_q.size() == 0) return;
            if (stray_en && exp_q.size() > 0 && $urandom_range(0, 7) == 0) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
            end
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: transaction still pending after 300 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_tx_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL tx_valid_timeout: tx_valid never rose (cycle %0d)", cyc);
    endtask

    task automatic clear_log();
        tx_log.delete();
        tx_cyc.delete();
    endtask

    task automatic check_log2(input string name, input logic [7:0] e0, e1);
        check({name, "_count"}, tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check({name, "_b0"}, tx_log[0], e0);
            check({name, "_b1"}, tx_log[1], e1);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
        rx_valid8 = 1'b0; rx_data8 = '0; tx_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", dbg_state, GET_A);
        @(posedge clk); #1;

        // Basic transaction: 0x1234 + 0x0011, ready always high.
        clear_log();
        send_txn(8'h34, 8'h12, 8'h11, 8'h00, 8'h20, 0);
        check("t1_alu_a", alu_a, 16'h1234);
        check("t1_alu_b", alu_b, 16'h0011);
        check("t1_alu_op", alu_op, 16'h0020);
        wait_idle();
        check_log2("t1_log", 8'h45, 8'h12);
        if (tx_cyc.size() == 2) begin
            check("t1_first_tx_cycle", tx_cyc[0], op_cyc + 2);
            check("t1_second_tx_cycle", tx_cyc[1], op_cyc + 3);
        end
        check("t1_state_back", dbg_state, GET_A);

        // Back-pressure on byte 0 for five cycles.
        clear_log();
        tx_ready = 1'b0;
        send_txn(8'h34, 8'h12, 8'h11, 8'h00, 8'h20, 1);
        wait_tx_valid();
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", tx_valid, 1);
            check("t2_hold_data", tx_data, 8'h45);
            @(posedge clk); #1;
        end
        check("t2_nothing_sent", tx_log.size(), 0);
        tx_ready = 1'b1;
        wait_idle();
        check_log2("t2_log", 8'h45, 8'h12);

        // Stray byte during SEND sets overrun and changes nothing else.
        clear_log();
        tx_ready = 1'b0;
        send_txn(8'h34, 8'h12, 8'h11, 8'h00, 8'h20, 0);
        wait_tx_valid();
        @(posedge clk); #1;
        rx_data = 8'hFF; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("t3_overrun_set", overrun, 1);
        check("t3_data_intact", tx_data, 8'h45);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_idle();
        check_log2("t3_log", 8'h45, 8'h12);
        clear_log();
        send_txn(8'h01, 8'h00, 8'h02, 8'h00, 8'h20, 2);
        wait_idle();
        check_log2("t3_next_log", 8'h03, 8'h00);
        check("t3_overrun_sticky", overrun, 1);

        // Reset in the middle of collecting operands.
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h11, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_alu_a", alu_a, 0);
        check("t4_alu_b", alu_b, 0);
        check("t4_alu_op", alu_op, 0);
        check("t4_tx_valid", tx_valid, 0);
        check("t4_overrun", overrun, 0);
        check("t4_state", dbg_state, GET_A);
        @(posedge clk); #1;
        clear_log();
        send_txn(8'h05, 8'h00, 8'h06, 8'h00, 8'h20, 0);
        wait_idle();
        check_log2("t4_log", 8'h0B, 8'h00);

        // Back-to-back transactions, including wrap-around.
        clear_log();
        send_txn(8'hFF, 8'hFF, 8'h01, 8'h00, 8'h20, 0);
        wait_idle();
        check_log2("t5_wrap_log", 8'h00, 8'h00);
        for (int t = 0; t < 2; t++) begin
            send_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
            wait_idle();
        end

        // Randomized traffic: gaps, random ready, stray bytes while busy.
        rdy_rand = 1;
        stray_en = 1;
        for (int t = 0; t < 25; t++) begin
            send_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3);
            wait_idle();
        end
        rdy_rand = 0;
        stray_en = 0;
        @(posedge clk); #1;
        tx_ready = 1'b1;

        // 8-bit instance: 0x7F + 0x01 -> single byte 0x80.
        rx_data8 = 8'h7F; rx_valid8 = 1'b1;
        @(posedge clk); #1;
        rx_data8 = 8'h01;
        @(posedge clk); #1;
        rx_data8 = 8'h20;
        op_cyc = cyc;
        @(posedge clk); #1;
        rx_valid8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b8_count", log8.size(), 1);
        if (log8.size() == 1) begin
            check("b8_byte", log8[0], 8'h80);
            check("b8_tx_cycle", cyc8[0], op_cyc + 2);
        end
        check("b8_alu_a", alu_a8, 8'h7F);
        check("b8_alu_b", alu_b8, 8'h01);
        check("b8_alu_op", alu_op8, 8'h20);
        check("b8_tx_valid_low", tx_valid8, 0);
        check("b8_state", dbg_state8, GET_A);
        check("b8_overrun", overrun8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Sits directly upstream of the combinational Alu (ports A, B, O, R) and downstream of the UART receiver.
- Assembles operands A and B (BITS wide, little-endian) and a 1-byte opcode from a byte stream, then drives them into the Alu.
- Samples R one cycle later and serialises R back out as bytes to the UART transmitter over a valid/ready handshake.

Parameters:
- BITS, 16, operand/result width. Must be a multiple of 8 and at least 8.
- NBYTES, BITS/8, bytes per operand. Local constant, not overridable.

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe: rx_data valid this cycle
- alu_a  out  BITS  operand A to Alu.A
- alu_b  out  BITS  operand B to Alu.B
- alu_op  out  BITS  opcode to Alu.O, zero-extended from 8 bits
- alu_r  in  BITS  result from Alu.R
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid and tx_ready are both high
- overrun  out  1  sticky: an rx byte arrived while not accepting input

Behaviour:
- Reset: all of the following are 0: alu_a, alu_b, alu_op, tx_data, tx_valid, overrun, byte counter, result register. State is GET_A.
- Reset applies mid-operation in any state and discards partial operands.
- FSM states and transitions:
  - GET_A: each rx_valid writes rx_data into alu_a byte[cnt] and increments cnt. When byte NBYTES-1 is accepted: cnt returns to 0, next state GET_B.
  - GET_B: same as GET_A, writing alu_b. Next state GET_OP.
  - GET_OP: the first rx_valid loads alu_op = {zeros, rx_data}. Next state EXEC.
  - EXEC: one cycle only, so the Alu settles on the registered inputs. At the end of the cycle, alu_r is captured into the result register and cnt is cleared. Next state SEND.
  - SEND: tx_valid=1 and tx_data = result byte[cnt], LSB first. On tx_valid&&tx_ready, cnt increments. When the last byte is accepted, next state is GET_A and tx_valid drops the following cycle.
- tx_data and tx_valid hold stable while tx_ready is low; there is no timeout.
- Latency: opcode byte accepted at cycle n; EXEC in n+1; tx_valid first high in n+2. Minimum n+2+NBYTES cycles to return to GET_A with tx_ready tied high.
- alu_a, alu_b and alu_op hold their values through EXEC and SEND. During GET_A and GET_B they update byte-by-byte; the Alu output is don't-care in those states.
- rx_valid during EXEC or SEND: the byte is dropped and overrun is set to 1. overrun clears only on rst.
- Simultaneous rx_valid and the last tx handshake in the same cycle: the rx byte is dropped (state is still SEND) and overrun is set.
- Byte counter width is clog2(NBYTES) with a minimum of 1 bit. When BITS=8, each operand is one byte.
- No arithmetic is performed in this block. Result bytes are sent verbatim from the captured alu_r.

Decomposition:
- Shared package holds:
  - state enum: GET_A, GET_B, GET_OP, EXEC, SEND (3-bit encoding)
  - BYTE_W=8
  - default BITS=16
- One natural sub-module: byte_deserializer, a shift/insert register with counter and done pulse, instantiated for each of A and B. The SEND serialiser stays inline in the FSM.

Test Plan:
- Reset then bytes 34,12 / 11,00 / 20 (hex); bench Alu stub gives R=A+B → alu_a=0x1234, alu_b=0x0011, alu_op=0x0020. tx emits 0x45 then 0x12 starting 2 cycles after the opcode byte. Back to GET_A.
- Same transaction with tx_ready low for 5 cycles on byte 0 → tx_data stays 0x45 and tx_valid stays 1 throughout. Byte 1 is sent only after ready goes high.
- rx_valid pulse with 0xFF during SEND → byte ignored, overrun=1, transmitted result unchanged. The next transaction still completes correctly with overrun still 1.
- Assert rst after two A bytes and one B byte → all outputs 0, state GET_A. The next five bytes form a fresh transaction.
- Back-to-back: 3 transactions with rx_valid every cycle in input states and tx_ready=1 → each result matches stub A+B with wrap-around (0xFFFF+0x0001 → 0x0000 sent as 00,00).
- BITS=8 instance: bytes 7F, 01, 20 → single tx byte 0x80, 2 cycles after the opcode byte.
